account_arbiter: RTL and testbench
==================================

# account_arbiter

Round-robin arbiter and sequencer for one shared account balance accessed by up to NUM_REQ concurrent ATM sessions (e.g. several terminals on a joint account). Each session requests a withdraw, deposit or inquiry. The block grants exactly one session at a time, executes the operation atomically on the internal balance register, and returns a one-cycle done/error response to the granted session. It sits between the per-terminal ATM FSMs and the account balance store.

## Interface
- NUM_REQ, 4, number of requesting sessions (2..8)
- BALANCE_WIDTH, 20, balance and value width in bits
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- load_en  in  1  load balance from load_value; honoured in IDLE only
- load_value  in  BALANCE_WIDTH  initial or replacement balance
- req  in  NUM_REQ  per-session request level
- req_op  in  2*NUM_REQ  op for session i at bits [2i+1:2i]: 00 withdraw, 01 deposit, 10 inquiry, 11 illegal
- req_value  in  BALANCE_WIDTH*NUM_REQ  amount for session i at slice i; ignored for inquiry
- grant  out  NUM_REQ  one-hot; high for the served session during EXEC and RESP
- done  out  NUM_REQ  one-cycle pulse to the served session in RESP
- error  out  NUM_REQ  one-cycle pulse coincident with done when the op was rejected
- balance_out  out  BALANCE_WIDTH  current balance register
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, EXEC, RESP.
- Reset: state IDLE. grant, done, error, busy, balance_out and round-robin pointer ptr all 0.
- IDLE, load_en=1:
  - balance <= load_value.
  - All requests are held off that cycle; load has priority.
  - State stays IDLE.
- IDLE, load_en=0 and req!=0:
  - Select the first asserted req at index ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - Latch sel, req_op[sel] and req_value[sel].
  - grant[sel] <= 1. Go to EXEC.
- EXEC: the op is evaluated on the latched copies only, so later changes to req, req_op or req_value have no effect.
  - Withdraw: value > balance -> error, balance unchanged. Otherwise balance <= balance - value. value == balance is legal and gives 0.
  - Deposit: compute a BALANCE_WIDTH+1-bit sum. If the carry bit is set -> error, balance unchanged. Otherwise balance <= sum.
  - Inquiry: no change, no error.
  - Op 11: error, no change.
  - Register done[sel]=1 and error[sel] as above. Go to RESP.
- RESP:
  - done/error visible for exactly this cycle.
  - balance_out shows the post-op value.
  - On exit: grant cleared, ptr <= (sel+1) mod NUM_REQ, state IDLE.
- A session keeping req high after done is treated as a new request and competes normally. ptr guarantees that every other pending session is served before it again.
- A session dropping req after being granted: the latched op still completes and done is still pulsed.
- load_en outside IDLE is ignored, not queued.
- rst asserted mid-operation: immediately returns to reset values. No done is emitted, and the balance is 0 until reloaded.

## Timing
- Request sampled at edge t (in IDLE) -> grant high from t+1 -> balance updated and done/error high at t+2 -> grant and done low at t+3.
- Minimum 3 cycles per operation. Maximum throughput is 1 op per 3 cycles with no idle bubble between back-to-back requests.
- Worst-case wait for a continuously requesting session: (NUM_REQ-1)*3 cycles after the current op completes.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Load 1000, session 0 withdraw 300 -> grant[0] at t+1, done[0] at t+2, error=0, balance_out=700.
- Balance 700, session 2 withdraw 701 -> done[2] and error[2] together, balance stays 700. Then withdraw 700 -> balance 0, no error.
- Balance 2^20-10, session 1 deposit 10 -> error[1], balance unchanged. Deposit 9 -> balance 2^20-1, no error.
- All 4 sessions hold req (deposit 1 each) from ptr=0 -> grants in order 0,1,2,3,0. Each op spans 3 cycles, balance increments by 1 per op.
- Session 3 op 11 -> error[3]. Inquiry by session 1 -> done without error, balance unchanged.
- rst pulsed during EXEC of withdraw 50 -> no done, all outputs 0. load_en during busy ignored, then honoured once back in IDLE.

Source files
------------

// File: rtl/account_arbiter.sv
// Round-robin arbiter serialising withdraw/deposit/inquiry ops onto one shared balance register.
// Each op takes IDLE->EXEC->RESP (3 cycles); all outputs are registered.
module account_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int BALANCE_WIDTH = 20
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load_en,
   input  logic [BALANCE_WIDTH-1:0]         load_value,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [2*NUM_REQ-1:0]             req_op,
   input  logic [BALANCE_WIDTH*NUM_REQ-1:0] req_value,
   output logic [NUM_REQ-1:0]               grant,
   output logic [NUM_REQ-1:0]               done,
   output logic [NUM_REQ-1:0]               error,
   output logic [BALANCE_WIDTH-1:0]         balance_out,
   output logic                             busy
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [1:0] OP_WD = 2'b00, OP_DEP = 2'b01, OP_INQ = 2'b10;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                   state, state_nxt;
   logic [PW-1:0]            ptr, ptr_nxt, sel, sel_nxt;
   logic [1:0]               op, op_nxt;
   logic [BALANCE_WIDTH-1:0] value, value_nxt, balance_nxt;
   logic [NUM_REQ-1:0]       grant_nxt, done_nxt, error_nxt;
   logic                     busy_nxt, err, found;
   logic [BALANCE_WIDTH:0]   sum;
   int                       pick, idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         sel         <= '0;
         op          <= '0;
         value       <= '0;
         balance_out <= '0;
         grant       <= '0;
         done        <= '0;
         error       <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         sel         <= sel_nxt;
         op          <= op_nxt;
         value       <= value_nxt;
         balance_out <= balance_nxt;
         grant       <= grant_nxt;
         done        <= done_nxt;
         error       <= error_nxt;
         busy        <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      sel_nxt     = sel;
      op_nxt      = op;
      value_nxt   = value;
      balance_nxt = balance_out;
      grant_nxt   = grant;
      done_nxt    = '0;
      error_nxt   = '0;
      busy_nxt    = busy;
      err         = 1'b0;
      found       = 1'b0;
      pick        = 0;
      idx         = 0;
      sum         = {1'b0, balance_out} + {1'b0, value};

      // first asserted request at ptr, ptr+1, ... wrapping
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end

      case (state)
         IDLE: begin
            if (load_en) begin
               balance_nxt = load_value;
            end else if (found) begin
               sel_nxt         = PW'(pick);
               op_nxt          = req_op[2*pick +: 2];
               value_nxt       = req_value[pick*BALANCE_WIDTH +: BALANCE_WIDTH];
               grant_nxt       = '0;
               grant_nxt[pick] = 1'b1;
               busy_nxt        = 1'b1;
               state_nxt       = EXEC;
            end
         end
         EXEC: begin
            case (op)
               OP_WD: begin
                  if (value > balance_out) err = 1'b1;
                  else balance_nxt = balance_out - value;
               end
               OP_DEP: begin
                  if (sum[BALANCE_WIDTH]) err = 1'b1;
                  else balance_nxt = sum[BALANCE_WIDTH-1:0];
               end
               OP_INQ:  err = 1'b0;
               default: err = 1'b1;
            endcase
            done_nxt[sel]  = 1'b1;
            error_nxt[sel] = err;
            state_nxt      = RESP;
         end
         RESP: begin
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            ptr_nxt   = (sel == PW'(NUM_REQ-1)) ? '0 : sel + PW'(1);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_account_arbiter.sv
// Directed bench for account_arbiter: hand-computed balances, grant order and response timing.
module tb_account_arbiter;

   localparam int N  = 4;
   localparam int BW = 20;

   logic              clk, rst, load_en, busy;
   logic [BW-1:0]     load_value, balance_out;
   logic [N-1:0]      req, grant, done, error;
   logic [2*N-1:0]    req_op;
   logic [BW*N-1:0]   req_value;

   int checks = 0;
   int passed = 0;

   account_arbiter #(.NUM_REQ(N), .BALANCE_WIDTH(BW)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_value(load_value),
      .req(req), .req_op(req_op), .req_value(req_value),
      .grant(grant), .done(done), .error(error),
      .balance_out(balance_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic load(input logic [BW-1:0] v);
      load_en = 1'b1;
      load_value = v;
      @(negedge clk);
      load_en = 1'b0;
      check("load", 32'(balance_out), 32'(v));
   endtask

   // issue one op, drop req and scramble inputs after grant to prove latching
   task automatic do_op(input int s, input logic [1:0] o, input logic [BW-1:0] v,
                        input bit exp_err, input logic [BW-1:0] exp_bal);
      logic [N-1:0] oh;
      oh = '0;
      oh[s] = 1'b1;
      req = oh;
      req_op[2*s +: 2] = o;
      req_value[s*BW +: BW] = v;
      @(negedge clk);
      check("grant", 32'(grant), 32'(oh));
      check("busy_exec", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      req = '0;
      req_op = '1;
      req_value = '1;
      @(negedge clk);
      check("done", 32'(done), 32'(oh));
      check("error", 32'(error), exp_err ? 32'(oh) : 32'd0);
      check("balance", 32'(balance_out), 32'(exp_bal));
      @(negedge clk);
      check("grant_clr", 32'(grant), 32'd0);
      check("done_clr", 32'(done), 32'd0);
      check("busy_clr", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      load_en = 1'b0;
      load_value = '0;
      req = '0;
      req_op = '0;
      req_value = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_balance", 32'(balance_out), 32'd0);
      rst = 1'b0;

      load(20'd1000);
      do_op(0, 2'b00, 20'd300, 1'b0, 20'd700);
      do_op(2, 2'b00, 20'd701, 1'b1, 20'd700);
      do_op(2, 2'b00, 20'd700, 1'b0, 20'd0);
      load(20'hFFFF6);
      do_op(1, 2'b01, 20'd10, 1'b1, 20'hFFFF6);
      do_op(1, 2'b01, 20'd9, 1'b0, 20'hFFFFF);
      do_op(1, 2'b10, 20'd55, 1'b0, 20'hFFFFF);
      do_op(3, 2'b11, 20'd1, 1'b1, 20'hFFFFF);   // ptr wraps to 0

      // all sessions hold deposit-1 requests: expect 0,1,2,3,0
      load(20'd100);
      req_op = 8'b01010101;
      for (int i = 0; i < N; i++) req_value[i*BW +: BW] = 20'd1;
      req = '1;
      for (int k = 0; k < 5; k++) begin
         logic [N-1:0] oh;
         oh = '0;
         oh[k % N] = 1'b1;
         @(negedge clk);
         check("rr_grant", 32'(grant), 32'(oh));
         @(negedge clk);
         check("rr_done", 32'(done), 32'(oh));
         check("rr_balance", 32'(balance_out), 32'(101 + k));
         @(negedge clk);
         check("rr_idle", 32'(grant), 32'd0);
         if (k == 4) req = '0;
      end

      // reset in the middle of a withdraw
      load(20'd500);
      req = 4'b0001;
      req_op[1:0] = 2'b00;
      req_value[BW-1:0] = 20'd50;
      @(negedge clk);
      check("mid_grant", 32'(grant), 32'd1);
      req = '0;
      rst = 1'b1;
      #1;
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_balance", 32'(balance_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_no_done", 32'(done), 32'd0);
      check("mid_bal_zero", 32'(balance_out), 32'd0);

      // load while busy is dropped; honoured once idle
      load(20'd500);
      req = 4'b0100;
      req_op[5:4] = 2'b00;
      req_value[2*BW +: BW] = 20'd100;
      @(negedge clk);
      req = '0;
      load_en = 1'b1;
      load_value = 20'd777;
      @(negedge clk);
      check("busy_load_done", 32'(done), 32'b0100);
      check("busy_load_bal", 32'(balance_out), 32'd400);
      @(negedge clk);
      check("busy_load_ign", 32'(balance_out), 32'd400);
      @(negedge clk);
      check("idle_load", 32'(balance_out), 32'd777);
      load_en = 1'b0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
